// File: rtl/divider_pkg.sv
// Shared constants and configuration record for the programmable modulo divider.
package divider_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DIV   = 6;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Modulus/mode pair held in both the shadow and the active register
  typedef struct packed {
    logic [DEF_WIDTH-1:0] modulus;
    logic                 mode;
  } cfg_t;

endpackage

// File: rtl/prog_modulo_divider_mod_counter.sv
// Modulo counter: counts 0..modulus-1 while enabled and flags the wrap cycle.
module mod_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic             wrap_c
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Terminal-count compare and next count
  always_comb begin
    count_d = count_q;
    wrap_c  = enable & (count_q == WIDTH'(modulus - WIDTH'(1)));
    if (enable) begin
      count_d = wrap_c ? '0 : WIDTH'(count_q + WIDTH'(1));
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/prog_modulo_divider.sv
// Runtime-programmable modulo-N counter / clock divider with glitch-free
// reconfiguration: new modulus/mode waits in a shadow register until a wrap.
// Optional macro WRAP_CNT_EN adds a 16-bit wrap counter on wrap_count.
module prog_modulo_divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned DEFAULT_DIV  = DEF_DIV,
  parameter bit          DEFAULT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             mode_in,
  input  logic             div_load,
  output logic [WIDTH-1:0] state,
  output logic             tc,
  output logic             out,
  output logic             pending,
  output logic             err,
  output logic [15:0]      wrap_count
);

  localparam cfg_t CFG_RST = '{modulus: DEF_WIDTH'(DEFAULT_DIV), mode: DEFAULT_MODE};

  cfg_t active_q, active_d;
  cfg_t shadow_q, shadow_d;
  logic pending_q, pending_d;
  logic err_q, err_d;
  logic tc_q, tc_d;
  logic out_q, out_d;
  logic wrap_c;

  mod_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .modulus (WIDTH'(active_q.modulus)),
    .count   (state),
    .wrap_c  (wrap_c)
  );

  // Output, shadow and config-apply logic; wrap applies the pre-edge shadow
  // before any same-edge load is captured, so that load waits for the next wrap
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    err_d     = err_q;
    tc_d      = wrap_c;
    out_d     = (active_q.mode == MODE_PULSE) ? wrap_c : (out_q ^ wrap_c);
    if (wrap_c && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (div_load) begin
      if (div_in >= WIDTH'(2)) begin
        shadow_d  = '{modulus: DEF_WIDTH'(div_in), mode: mode_in};
        pending_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Config and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= CFG_RST;
      shadow_q  <= CFG_RST;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      tc_q      <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      tc_q      <= tc_d;
      out_q     <= out_d;
    end
  end

  assign tc      = tc_q;
  assign out     = out_q;
  assign pending = pending_q;
  assign err     = err_q;

`ifdef WRAP_CNT_EN
  logic [15:0] wrap_cnt_q, wrap_cnt_d;

  // Wrap counter; the wrap that applies a new config restarts it at zero
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_c) begin
      wrap_cnt_d = pending_q ? 16'h0000 : 16'(wrap_cnt_q + 16'd1);
    end
  end

  // Wrap counter register
  always_ff @(posedge clk) begin
    if (reset) wrap_cnt_q <= 16'h0000;
    else       wrap_cnt_q <= wrap_cnt_d;
  end

  assign wrap_count = wrap_cnt_q;
`else
  assign wrap_count = 16'h0000;
`endif

endmodule

// File: tb/tb_prog_modulo_divider.sv
// Directed, table-driven bench for prog_modulo_divider.
module tb_prog_modulo_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] div_in;
  logic       mode_in;
  logic       div_load;
  logic [7:0] state;
  logic       tc;
  logic       out;
  logic       pending;
  logic       err;
  logic [15:0] wrap_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ld;
    logic [7:0] div;
    logic       mode;
    logic [7:0] e_state;
    logic       e_tc;
    logic       e_out;
    logic       e_pend;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  prog_modulo_divider dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .div_in     (div_in),
    .mode_in    (mode_in),
    .div_load   (div_load),
    .state      (state),
    .tc         (tc),
    .out        (out),
    .pending    (pending),
    .err        (err),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs for one edge, then sample just after it
  task automatic apply(input logic r, input logic e, input logic l, input logic [7:0] d, input logic m);
    reset = r; enable = e; div_load = l; div_in = d; mode_in = m;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic e, input logic l, input logic [7:0] d, input logic m,
                     input logic [7:0] s, input logic t, input logic o, input logic p, input logic er);
    vecs.push_back('{rst: r, en: e, ld: l, div: d, mode: m,
                     e_state: s, e_tc: t, e_out: o, e_pend: p, e_err: er});
  endtask

  // Plain count step with no load
  task automatic cnt(input logic [7:0] s, input logic t, input logic o, input logic p, input logic er);
    add(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, s, t, o, p, er);
  endtask

  initial begin
    int cycles;
    logic [7:0] prev;
    reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_in = 8'd0; mode_in = 1'b0;

    // Reset, then default divide-by-6 toggle
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cnt(1,0,0,0,0); cnt(2,0,0,0,0); cnt(3,0,0,0,0); cnt(4,0,0,0,0); cnt(5,0,0,0,0);
    cnt(0,1,1,0,0);
    cnt(1,0,1,0,0); cnt(2,0,1,0,0); cnt(3,0,1,0,0); cnt(4,0,1,0,0); cnt(5,0,1,0,0);
    cnt(0,1,0,0,0);
    // Load 3/pulse at state 2; applies at the next wrap
    cnt(1,0,0,0,0); cnt(2,0,0,0,0);
    add(0, 1, 1, 3, 1, 3, 0, 0, 1, 0);
    cnt(4,0,0,1,0); cnt(5,0,0,1,0);
    cnt(0,1,1,0,0);
    cnt(1,0,0,0,0); cnt(2,0,0,0,0); cnt(0,1,1,0,0);
    cnt(1,0,0,0,0); cnt(2,0,0,0,0); cnt(0,1,1,0,0);
    // Illegal loads set sticky err, modulus stays 6
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1, 0, 0, 0, 1);
    add(0, 1, 1, 0, 1, 2, 0, 0, 0, 1);
    cnt(3,0,0,0,1); cnt(4,0,0,0,1); cnt(5,0,0,0,1); cnt(0,1,1,0,1);
    // Enable low holds everything
    cnt(1,0,1,0,1); cnt(2,0,1,0,1); cnt(3,0,1,0,1); cnt(4,0,1,0,1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 4, 0, 1, 0, 1);
    cnt(5,0,1,0,1); cnt(0,1,0,0,1);
    // Load on the wrap edge: old modulus for one more round, then 4
    cnt(1,0,0,0,1); cnt(2,0,0,0,1); cnt(3,0,0,0,1); cnt(4,0,0,0,1); cnt(5,0,0,0,1);
    add(0, 1, 1, 4, 0, 0, 1, 1, 1, 1);
    cnt(1,0,1,1,1); cnt(2,0,1,1,1); cnt(3,0,1,1,1); cnt(4,0,1,1,1); cnt(5,0,1,1,1);
    cnt(0,1,0,0,1);
    cnt(1,0,0,0,1); cnt(2,0,0,0,1); cnt(3,0,0,0,1); cnt(0,1,1,0,1); cnt(1,0,1,0,1);
    // Reset mid-count with pending and err; reset beats a load
    add(0, 1, 1, 5, 0, 2, 0, 1, 1, 1);
    cnt(3,0,1,1,1);
    add(1, 1, 1, 7, 1, 0, 0, 0, 0, 0);
    cnt(1,0,0,0,0); cnt(2,0,0,0,0); cnt(3,0,0,0,0); cnt(4,0,0,0,0); cnt(5,0,0,0,0);
    cnt(0,1,1,0,0);
    // Last load wins: 9 then 2/pulse, minimum modulus
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 9, 0, 1, 0, 0, 1, 0);
    add(0, 1, 1, 2, 1, 2, 0, 0, 1, 0);
    cnt(3,0,0,1,0); cnt(4,0,0,1,0); cnt(5,0,0,1,0);
    cnt(0,1,1,0,0);
    cnt(1,0,0,0,0); cnt(0,1,1,0,0); cnt(1,0,0,0,0); cnt(0,1,1,0,0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].div, vecs[i].mode);
      check($sformatf("v%0d.state", i), 32'(state),   32'(vecs[i].e_state));
      check($sformatf("v%0d.tc", i),    32'(tc),      32'(vecs[i].e_tc));
      check($sformatf("v%0d.out", i),   32'(out),     32'(vecs[i].e_out));
      check($sformatf("v%0d.pend", i),  32'(pending), 32'(vecs[i].e_pend));
      check($sformatf("v%0d.err", i),   32'(err),     32'(vecs[i].e_err));
`ifndef WRAP_CNT_EN
      check($sformatf("v%0d.wcnt", i),  32'(wrap_count), 32'd0);
`endif
    end

    // Maximum modulus 255: wrap must come 255 edges after the previous one
    apply(1, 1, 0, 0, 0);
    check("max.rst_wcnt", 32'(wrap_count), 32'd0);
    apply(0, 1, 1, 8'd255, 0);
    check("max.pend", 32'(pending), 32'd1);
    repeat (4) apply(0, 1, 0, 0, 0);
    check("max.pre_state", 32'(state), 32'd5);
    apply(0, 1, 0, 0, 0);
    check("max.apply_tc", 32'(tc), 32'd1);
    check("max.apply_out", 32'(out), 32'd1);
    check("max.apply_pend", 32'(pending), 32'd0);
    check("max.apply_wcnt", 32'(wrap_count), 32'd0);
    cycles = 0;
    prev = state;
    do begin
      prev = state;
      apply(0, 1, 0, 0, 0);
      cycles++;
    end while (!tc && cycles < 300);
    check("max.period", 32'(cycles), 32'd255);
    check("max.last_state", 32'(prev), 32'd254);
    check("max.wrap_state", 32'(state), 32'd0);
    check("max.out", 32'(out), 32'd0);
`ifdef WRAP_CNT_EN
    check("max.wcnt", 32'(wrap_count), 32'd1);
`else
    check("max.wcnt", 32'(wrap_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_modulo_divider.md
Name: prog_modulo_divider

Overview:
Runtime-programmable modulo-N counter and clock-enable/clock divider, replacing fixed divide-by-6 blocks.
- Counts 0..N-1. Produces a toggle output (period 2N) or a one-cycle pulse output (period N), selectable per load.
- New modulus/mode is loaded through a shadow register and applied only at a wrap, so output periods never glitch.
- Sits between the system clock and downstream slow-rate logic (display scan, debouncers, LED blink).

Parameters:
WIDTH, 8, counter/modulus width in bits; legal modulus 2..2^WIDTH-1
DEFAULT_DIV, 6, modulus after reset
DEFAULT_MODE, 0, mode after reset (0 = toggle, 1 = pulse)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; wins over all other inputs
enable  in  1  count advance enable
div_in  in  WIDTH  requested modulus N
mode_in  in  1  requested mode: 0 toggle, 1 pulse
div_load  in  1  one-cycle strobe; captures div_in/mode_in into shadow
state  out  WIDTH  current count (0..N-1)
tc  out  1  registered; high for the one cycle after a wrap edge (state==0)
out  out  1  divided output
pending  out  1  shadow config waiting to be applied
err  out  1  sticky: an illegal modulus (0 or 1) was loaded
wrap_count  out  16  wrap counter (see Optional Feature)

Behaviour:
- Reset (at edge, reset=1): state=0, tc=0, out=0, pending=0, err=0, active modulus=DEFAULT_DIV, active mode=DEFAULT_MODE, shadow=defaults.
- wrap = enable & (state == active_mod-1).
- Per edge, enable=1 and no wrap: state+1, tc=0.
- Per edge, wrap: state=0, tc=1.
- Per edge, enable=0: state, out and config hold; tc=0. Pending stays pending.
- out, toggle mode: out_d = wrap ? ~out : out. Gives period 2N, 50% duty.
- out, pulse mode: out_d = wrap. out equals tc, period N.
- out always uses the mode active before the edge.
- div_load with div_in>=2: shadow <= {div_in, mode_in}, pending=1.
- div_load with div_in<2: shadow and pending unchanged, err=1. err clears only on reset.
- div_load while pending=1: shadow overwritten (last load wins).
- Wrap with pending=1: active config <= shadow, pending=0. Counting restarts at 0 under the new modulus.
- div_load on the same edge as a wrap: the wrap applies the pre-edge shadow (or nothing, if pending=0). The new load becomes pending for the following wrap.
- Arithmetic: unsigned WIDTH-bit increment. No overflow is possible because state <= 2^WIDTH-2.
- Reset mid-count or with pending: full reset values on that edge. The pending load is discarded.
- Latency: the config applies at the first wrap after the load edge. Wrap to tc/out is one edge (registered).

Optional Feature:
Macro WRAP_CNT_EN.
- Defined: wrap_count is a 16-bit counter, +1 on every wrap, rolling 0xFFFF->0x0000. Cleared on reset and on the edge a pending config is applied (that wrap counts as 0).
- Not defined: wrap_count tied to 0, no flops inferred.

Decomposition:
- Shared package (divider_pkg):
  - MODE_TOGGLE=1'b0, MODE_PULSE=1'b1
  - default WIDTH/DEFAULT_DIV constants
  - cfg struct/typedef {modulus, mode} used for both the shadow and active registers.
- One sub-module, mod_counter: WIDTH-bit register with synchronous clear, enable, and terminal-count compare against a modulus input, emitting wrap.
- Config shadow, output and tc logic stay in the top.

Test Plan:
1. Reset, enable=1, no loads -> state 0,1,2,3,4,5,0...; tc every 6 cycles; out toggles each wrap (12-cycle period); pending=0, err=0.
2. At state=2, div_load div_in=3 mode_in=1 -> pending=1; state 3,4,5,0,1,2,0,1,2; pending=0 at first wrap; afterwards out high exactly when state==0 (period 3).
3. div_load div_in=1, then div_in=0 -> err=1 stays high; modulus stays 6, pending stays 0; only reset clears err.
4. enable=0 for 4 cycles at state=4 -> state holds 4, tc=0, out holds; enable=1 -> 5, then 0 with tc=1.
5. div_load div_in=4 on the edge where state=5 (pending=0) -> wraps to 0 under modulus 6 (0..5 again), then 0..3 repeating.
6. Reset at state=3 with pending=1, err=1 -> next edge: state=0, out=0, tc=0, pending=0, err=0, modulus 6. With WRAP_CNT_EN defined: also wrap_count=0, and 70000 wraps -> wrap_count=4464.
